// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, types and round functions shared by the engine.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } work_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t [0:7] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t [0:7] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic work_t round_f(input work_t s, input word_t k, input word_t w);
        word_t t1;
        word_t t2;
        work_t r;
        t1 = s.h + bsig1(s.e) + ch(s.e, s.f, s.g) + k + w;
        t2 = bsig0(s.a) + maj(s.a, s.b, s.c);
        r = '{a: t1 + t2, b: s.a, c: s.b, d: s.c, e: s.d + t1, f: s.e, g: s.f, h: s.g};
        return r;
    endfunction

endpackage

// File: rtl/sha256_sched.sv
// rtl/sha256_sched.sv - 16-word message schedule window, parallel load and R-word shift with expansion.
module sha256_sched
    import sha256_pkg::*;
#(
    parameter int R = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [511:0]   blk,
    input  logic           shift,
    output word_t [R-1:0]  w
);

    word_t win [16];
    word_t nxt [16];

    // Words appended late in the same cycle may feed later ones (R=4 uses W[t+16], W[t+17]).
    always_comb begin
        word_t ext [16+R];
        for (int i = 0; i < 16; i++) ext[i] = win[i];
        for (int j = 0; j < R; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        for (int i = 0; i < 16; i++) nxt[i] = ext[i+R];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) win[i] <= blk[511-32*i -: 32];
        end else if (shift) begin
            for (int i = 0; i < 16; i++) win[i] <= nxt[i];
        end
    end

    for (genvar j = 0; j < R; j++) begin : g_out
        assign w[j] = win[j];
    end

endmodule

// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - multi-block SHA-256 engine, R rounds per cycle; SHA256_STREAM_SHA224_EN adds SHA-224 mode.
module sha256_stream
    import sha256_pkg::*;
#(
    parameter int N       = 32,
    parameter int R       = 1,
    parameter int OUT_REG = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            blk_valid_i,
    output logic            blk_ready_o,
    input  logic [N*16-1:0] blk_i,
    input  logic            first_i,
    input  logic            last_i,
`ifdef SHA256_STREAM_SHA224_EN
    input  logic            mode224_i,
`endif
    output logic            busy_o,
    output logic            digest_valid_o,
    output logic [255:0]    digest_o
);

    if (N != 32) begin : g_bad_n
        $error("sha256_stream: N must be 32");
    end
    if (R != 1 && R != 2 && R != 4) begin : g_bad_r
        $error("sha256_stream: R must be 1, 2 or 4");
    end

    state_e        state, state_nx;
    word_t [0:7]   h_q, h_sum, iv, v_w;
    work_t         v_q, v_nx;
    logic [5:0]    cnt;
    logic          last_q, mode_q, mode_in, hs;
    word_t [R-1:0] w_r;
    logic [255:0]  hv;

`ifdef SHA256_STREAM_SHA224_EN
    assign mode_in = mode224_i;
`else
    assign mode_in = 1'b0;
`endif

    assign hs  = blk_valid_i & blk_ready_o;
    assign iv  = mode_in ? IV224 : IV256;
    assign v_w = v_q;
    assign hv  = h_sum;

    sha256_sched #(.R(R)) u_sched (
        .clk   (clk_i),
        .rst_n (rst_i),
        .load  (hs),
        .blk   (blk_i),
        .shift (state == ROUND),
        .w     (w_r)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs) state_nx = ROUND;
            ROUND:   if (cnt == 6'(64 - R)) state_nx = FINAL;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        blk_ready_o = (state == IDLE);
        busy_o      = (state != IDLE);
    end

    always_comb begin
        v_nx = v_q;
        for (int j = 0; j < R; j++) v_nx = round_f(v_nx, K[cnt + 6'(j)], w_r[j]);
        for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_w[i];
    end

    // H is loaded with the IV at a first-block handshake, so FINAL always adds to h_q.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            h_q            <= IV256;
            v_q            <= '0;
            cnt            <= '0;
            last_q         <= 1'b0;
            mode_q         <= 1'b0;
            digest_valid_o <= 1'b0;
            digest_o       <= '0;
        end else begin
            if (OUT_REG == 0) digest_valid_o <= 1'b0;
            case (state)
                IDLE: if (hs) begin
                    v_q    <= first_i ? iv : h_q;
                    last_q <= last_i;
                    cnt    <= '0;
                    if (first_i) begin
                        h_q    <= iv;
                        mode_q <= mode_in;
                        if (OUT_REG != 0) begin
                            digest_valid_o <= 1'b0;
                            digest_o       <= '0;
                        end
                    end
                end
                ROUND: begin
                    v_q <= v_nx;
                    cnt <= cnt + 6'(R);
                end
                FINAL: begin
                    h_q <= h_sum;
                    if (last_q) begin
                        digest_valid_o <= 1'b1;
                        digest_o       <= mode_q ? {hv[255:32], 32'h0} : hv;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sha256_stream.md
Name: sha256_stream

Overview:
- Parametrised SHA-256 compression engine; successor to the single-block hash core.
- Accepts pre-padded 512-bit blocks over a valid/ready handshake.
- Chains the intermediate hash across blocks of one message and emits a registered 256-bit digest with a valid pulse after the last block.
- Throughput is scaled by processing R rounds per cycle.

Parameters:
- N, 32, word width; fixed at 32, elaborates an error otherwise.
- R, 1, rounds per cycle; legal values 1, 2, 4; elaborates an error otherwise.
- OUT_REG, 1, 1 = digest held in an output register until the next message starts; 0 = digest valid for one cycle only.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- blk_valid_i  in  1  block word array valid.
- blk_ready_o  out  1  engine can accept a block.
- blk_i  in  N*16  block, word 0 in bits [511:480], big-endian.
- first_i  in  1  block is the first of a message; load IV.
- last_i  in  1  block is the last of a message.
- busy_o  out  1  round or final state active.
- digest_valid_o  out  1  digest_o valid.
- digest_o  out  256  H0 in [255:224] ... H7 in [31:0].

Behaviour:
- Reset (rst_i low): FSM to IDLE; H regs to the SHA-256 IV; working regs, schedule window and round counter to 0. Outputs reset to: blk_ready_o=1, busy_o=0, digest_valid_o=0, digest_o=0. Reset mid-operation aborts the block, no digest is emitted.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - blk_ready_o=1.
  - On handshake (blk_valid_i & blk_ready_o): latch blk_i into the 16-word schedule window; latch first_i/last_i.
  - Working vars a..h <= IV if first_i, else H.
  - H <= IV when first_i. IV is added in FINAL.
  - round counter <= 0; go to ROUND.
- ROUND:
  - blk_ready_o=0, busy_o=1.
  - Each cycle applies R chained rounds t..t+R-1, using W[t] from the window and K[t] from the package constant.
  - Window shifts by R words per cycle; each new word is sigma1(W[t-2])+W[t-7]+sigma0(W[t-15])+W[t-16], computed mod 2^32.
  - Counter += R. After 64/R cycles go to FINAL.
- FINAL (1 cycle): H[i] <= H[i] + var[i] mod 2^32, where H is the IV when first_i was set. Then:
  - If last: digest_o <= new H; digest_valid_o=1 next cycle.
  - Return to IDLE.
- Latency: accept at cycle 0 -> digest_valid_o at cycle 64/R+2. Per block: 64/R+2 cycles, i.e. 66 cycles for R=1.
- Next block may handshake in the cycle digest_valid_o rises.
- Non-last block: digest_valid_o stays 0; H retained for chaining.
- first_i & last_i both set: single-block message.
- first_i=0 on a block following a completed message: chains from the last H; this is legal and not flagged.
- OUT_REG=0: digest_valid_o is a 1-cycle pulse.
- OUT_REG=1: digest_valid_o and digest_o hold until the next handshake with first_i=1, and clear in that cycle.
- blk_i, first_i and last_i are sampled only on handshake; changes while blk_ready_o=0 are ignored.
- All additions are modulo 2^32 with no carry out. The carry-out "unused" logic of the old core is dropped.

Optional Feature:
- Macro: SHA256_STREAM_SHA224_EN.
- Defined:
  - Adds port mode224_i (in, 1), sampled with first_i.
  - When set, the IV is the SHA-224 IV and digest_o[255:32] carries H0..H6, with [31:0] forced to 0.
- Undefined: port absent; SHA-256 only. Logic identical to mode224_i=0.

Decomposition:
- Package sha256_pkg: K[0:63] constant array; IV256[0:7] and IV224[0:7]; word_t typedef (logic [31:0]); state_e enum {IDLE, ROUND, FINAL}; functions ch, maj, bsig0, bsig1, ssig0, ssig1, and round_f (one round on an 8-word struct).
- Sub-module sha256_sched: 16-word sliding window, parallel load, R-word shift with expansion; outputs W[t..t+R-1].
- The round datapath stays in the top as R chained round_f calls.

Test Plan:
- "abc", single padded block, first=last=1, R=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad at cycle 66 after accept.
- Empty message (block 80000000, 0...) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; repeat with R=2 and R=4, latency 34 and 18 cycles.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with back-to-back valid -> no digest after block 1, then 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Pull rst_i low at round 30 of "abc", release, resend "abc" -> no digest from the aborted block; correct "abc" digest; blk_ready_o=1 immediately after reset.
- blk_valid_i held high with changing blk_i while busy -> only first block hashed; with OUT_REG=1 the digest holds until the next first_i handshake.
- With SHA256_STREAM_SHA224_EN defined and mode224_i=1, "abc" -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, low word 0.
